// File: rtl/sbox_engine_if.sv
// Handshake and state bus between a state producer and the substitution engine.
// Both directions use valid/ready flow control.
`timescale 1ns/1ps
interface sbox_engine_if #(
  parameter int NWORDS = 5,
  parameter int WORD_W = 64
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     bypass;
  logic [NWORDS*WORD_W-1:0] state_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [NWORDS*WORD_W-1:0] state_out;

  modport master (
    output in_valid, bypass, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, bypass, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/sbox_engine.sv
// Bitsliced chi-style substitution layer for an odd number of state words.
// Each cycle transforms SLICE_W bit-columns of every word, sweeping the full word width.
`timescale 1ns/1ps
module sbox_engine #(
  parameter int NWORDS  = 5,
  parameter int WORD_W  = 64,
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  sbox_engine_if.slave bus,
  output logic        done,
  output logic        busy
);

  localparam int MID     = (NWORDS - 1) / 2;
  localparam int NSLICES = WORD_W / SLICE_W;
  localparam int KW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  typedef logic [NWORDS-1:0][SLICE_W-1:0] cols_t;

  state_t                   state;
  logic [NWORDS*WORD_W-1:0] st;
  logic [KW-1:0]            k;
  logic                     byp;
  cols_t                    cur;
  cols_t                    nxt;

  // All column operations are bitwise, so a whole slice of columns is handled at once.
  function automatic cols_t sbox_cols(input cols_t x);
    cols_t b;
    cols_t t;
    b = x;
    t = '0;
    for (int i = 0; i <= MID; i++) b[2*i] = b[2*i] ^ b[(2*i + NWORDS - 1) % NWORDS];
    for (int i = 0; i < NWORDS; i++) t[i] = ~b[i] & b[(i + 1) % NWORDS];
    for (int i = 0; i < NWORDS; i++) b[i] = b[i] ^ t[(i + 1) % NWORDS];
    for (int i = 0; i <= MID; i++) b[(2*i + 1) % NWORDS] = b[(2*i + 1) % NWORDS] ^ b[2*i];
    b[MID] = ~b[MID];
    return b;
  endfunction

  always_comb begin
    cur = '0;
    for (int i = 0; i < NWORDS; i++) cur[i] = st[i*WORD_W + int'(k)*SLICE_W +: SLICE_W];
    nxt = byp ? cur : sbox_cols(cur);
  end

  assign bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign bus.out_valid = (state == HOLD);
  assign bus.state_out = st;
  assign busy          = (state == RUN);

  // Clear outranks every handshake, so a capture offered in the same cycle is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      st    <= '0;
      k     <= '0;
      byp   <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      st    <= '0;
      k     <= '0;
      byp   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            st    <= bus.state_in;
            byp   <= bus.bypass;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NWORDS; i++) st[i*WORD_W + int'(k)*SLICE_W +: SLICE_W] <= nxt[i];
          k <= k + 1'b1;
          if (k == KLAST) begin
            k     <= '0;
            done  <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              st    <= bus.state_in;
              byp   <= bus.bypass;
              k     <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
